// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and step-kind encoding for the up/down counter family.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents:
//   CNT_UP / CNT_DOWN  - values for the up_dn control input
//   CNT_WRAP / CNT_SAT - values for the sat control input
//   act_t              - what the counter does on the next edge
package mod_updown_counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;
  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  // ACT_WRAP and ACT_BLOCK are the two events that set the sticky overflow flag.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_STEP,
    ACT_WRAP,
    ACT_BLOCK
  } act_t;

endpackage

// File: rtl/mod_updown_counter_tff_sync.sv
// T flip-flop with synchronous active-high reset; one per counter bit.
// Latency: q toggles one clk edge after t is sampled high.
// Backpressure: none; t is sampled on every edge.
//
// Ports:
//   clk   in  1  clock
//   reset in  1  synchronous active-high reset, forces q to 0
//   t     in  1  toggle request
//   q     out 1  registered state
module tff_sync (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load, wrap/saturate mode, cascade tc, sticky ovf.
// Latency: q/wrap/ovf update one clk edge after inputs are sampled; tc is same-cycle.
// Backpressure: none; chain stages by driving the next stage's en from this tc.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   en, up_dn, sat      count enable, direction (1=up), saturate mode (1=saturate)
//   load, load_val      parallel load (wins over en); values >= MODULUS clamp to MODULUS-1
//   clr_ovf             clear the sticky overflow flag (a coincident set event wins)
//   q                   registered count, always in 0..MODULUS-1
//   tc                  en & (up_dn ? q==MODULUS-1 : q==0), independent of sat
//   wrap                one-cycle pulse after a wrap edge
//   ovf                 sticky: a wrap or blocked saturating step has occurred
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // MODULUS may equal 2**WIDTH, so the range bound needs one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] QMAX    = WIDTH'(MODULUS - 1);

  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   lv_ext;
  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t_vec;
  act_t             act;

  assign inc_ext = {1'b0, q} + (WIDTH + 1)'(1);
  assign lv_ext  = {1'b0, load_val};
  assign at_max  = (inc_ext == MOD_EXT);
  assign at_min  = (q == '0);

  assign tc = en & ((up_dn == CNT_UP) ? at_max : at_min);

  // Reset is not handled here: the bit flops reset themselves, which gives
  // reset priority over any load or count step computed below.
  always_comb begin
    act    = ACT_HOLD;
    q_next = q;
    if (load) begin
      act    = ACT_LOAD;
      q_next = (lv_ext >= MOD_EXT) ? QMAX : load_val;
    end else if (en) begin
      if (up_dn == CNT_UP) begin
        if (!at_max) begin
          act    = ACT_STEP;
          q_next = inc_ext[WIDTH-1:0];
        end else if (sat == CNT_SAT) begin
          act = ACT_BLOCK;
        end else begin
          act    = ACT_WRAP;
          q_next = '0;
        end
      end else begin
        if (!at_min) begin
          act    = ACT_STEP;
          q_next = q - WIDTH'(1);
        end else if (sat == CNT_SAT) begin
          act = ACT_BLOCK;
        end else begin
          act    = ACT_WRAP;
          q_next = QMAX;
        end
      end
    end
  end

  // Each bit toggles exactly when its next value differs from its current one.
  assign t_vec = q ^ q_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_sync u_tff (
      .clk   (clk),
      .reset (reset),
      .t     (t_vec[i]),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      wrap <= (act == ACT_WRAP);
      // Set beats clear when both happen on the same edge.
      ovf  <= (act == ACT_WRAP) | (act == ACT_BLOCK) | (ovf & ~clr_ovf);
    end
  end

endmodule
